step_profile_gen: RTL and testbench

Parametrised trapezoidal step-pulse generator for one stepper axis. It latches a move command (step count, max/min period, per-step period change, direction) on a start handshake, then emits step pulses that accelerate, cruise and decelerate symmetrically. It reports busy/done and a running step count. It sits between the motion command decoder and the stepper driver pins, one instance per axis.

---
 rtl/step_profile_gen.sv | 161 ++++++++++++++++
 tb/tb_step_profile_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator for one stepper axis: accelerate, cruise, decelerate.
// Optional soft stop on stop_req when STEP_SOFT_STOP_EN is defined.
module step_profile_gen #(
  parameter int W     = 32,
  parameter int ACC_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n_steps,
  input  logic [W-1:0] t_max,
  input  logic [W-1:0] t_min,
  input  logic [W-1:0] delta,
  input  logic         dir_in,
  input  logic         stop_req,
  output logic         busy,
  output logic         done,
  output logic         step,
  output logic         dir,
  output logic [W-1:0] step_num
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_e             state_q, state_d;
  logic [W-1:0]       n_q, n_d, tmin_q, tmin_d, tmax_q, tmax_d, delta_q, delta_d;
  logic [W-1:0]       delay_q, delay_d, cnt_q, cnt_d, step_num_q, step_num_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               dir_q, dir_d, done_q, done_d, step_q, step_d;

  logic [W-1:0]       tmin_in, tmax_in, snn, rem, acc_ext, inc_cl, dec_cl;
  logic [W:0]         inc_w, floor_w;

`ifndef STEP_SOFT_STOP_EN
  logic unused_stop_req;
  assign unused_stop_req = stop_req;
`endif

  always_comb begin
    tmin_in = (t_min < W'(2)) ? W'(2) : t_min;
    tmax_in = (t_max < tmin_in) ? tmin_in : t_max;
    snn     = step_num_q + W'(1);
    rem     = n_q - snn;
    acc_ext = W'(acc_q);
    // Ramp arithmetic in W+1 bits so neither direction can wrap past its clamp.
    inc_w   = {1'b0, delay_q} + {1'b0, delta_q};
    inc_cl  = (inc_w > {1'b0, tmax_q}) ? tmax_q : inc_w[W-1:0];
    floor_w = {1'b0, delta_q} + {1'b0, tmin_q};
    dec_cl  = (floor_w >= {1'b0, delay_q}) ? tmin_q : delay_q - delta_q;
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    tmin_d     = tmin_q;
    tmax_d     = tmax_q;
    delta_d    = delta_q;
    delay_d    = delay_q;
    cnt_d      = cnt_q;
    step_num_d = step_num_q;
    acc_d      = acc_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    step_d     = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        n_d        = n_steps;
        tmin_d     = tmin_in;
        tmax_d     = tmax_in;
        delta_d    = delta;
        dir_d      = dir_in;
        step_num_d = '0;
        if (n_steps == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ACCEL;
          delay_d = tmax_in;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
    end else begin
      // Registered from the current count, so the pulse trails cnt by one cycle.
      step_d = (cnt_q < (delay_q >> 1));
      if (cnt_q == delay_q - W'(1)) begin
        cnt_d      = '0;
        step_num_d = snn;
        if (snn == n_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef STEP_SOFT_STOP_EN
        else if (stop_req && (state_q != DECEL)) begin
          n_d = snn + acc_ext;
          if (acc_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DECEL;
            delay_d = inc_cl;
            acc_d   = acc_q - ACC_W'(1);
          end
        end
`endif
        else if (rem <= acc_ext) begin
          state_d = DECEL;
          delay_d = inc_cl;
          acc_d   = acc_q - ACC_W'(1);
        end else if ((state_q == ACCEL) && ({1'b0, rem} > ({1'b0, acc_ext} + (W+1)'(1)))
                     && (delay_q > tmin_q)) begin
          delay_d = dec_cl;
          acc_d   = (acc_q == ACC_MAX) ? acc_q : acc_q + ACC_W'(1);
          if (dec_cl == tmin_q) state_d = CRUISE;
        end else if (state_q == ACCEL) begin
          state_d = CRUISE;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      tmin_q     <= '0;
      tmax_q     <= '0;
      delta_q    <= '0;
      delay_q    <= '0;
      cnt_q      <= '0;
      step_num_q <= '0;
      acc_q      <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      tmin_q     <= tmin_d;
      tmax_q     <= tmax_d;
      delta_q    <= delta_d;
      delay_q    <= delay_d;
      cnt_q      <= cnt_d;
      step_num_q <= step_num_d;
      acc_q      <= acc_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      step_q     <= step_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign step_num = step_num_q;

endmodule

// File: tb/tb_step_profile_gen.sv
// Bench for step_profile_gen: period-list model expanded into an expected per-cycle waveform.
module tb_step_profile_gen;
  localparam int W = 32;
  localparam int ACC_W = 16;
`ifdef STEP_SOFT_STOP_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, dir_in = 1'b0, stop_req = 1'b0;
  logic [W-1:0] n_steps = '0, t_max = '0, t_min = '0, delta = '0;
  logic busy, done, step, dir;
  logic [W-1:0] step_num;

  step_profile_gen #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .n_steps(n_steps), .t_max(t_max),
    .t_min(t_min), .delta(delta), .dir_in(dir_in), .stop_req(stop_req),
    .busy(busy), .done(done), .step(step), .dir(dir), .step_num(step_num)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int bq[$];
  int plan_stop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Period of every step of a move, from the ramp rules applied step by step.
  function automatic void build(input longint n, input longint tmx, input longint tmn,
                                input longint dl, input int stop_at);
    longint te_min, te_max, d, acc, neff, rem;
    int ph;
    bq.delete();
    te_min = (tmn < 2) ? 2 : tmn;
    te_max = (tmx < te_min) ? te_min : tmx;
    d = te_max; acc = 0; ph = 0; neff = n;
    for (longint s = 1; s <= neff; s++) begin
      bq.push_back(int'(d));
      if (s == neff) break;
      rem = neff - s;
      if (SOFT && s == longint'(stop_at) && ph != 2) begin
        neff = s + acc;
        if (acc == 0) break;
        ph = 2; d = (d + dl > te_max) ? te_max : d + dl; acc--;
      end else if (rem <= acc) begin
        ph = 2; d = (d + dl > te_max) ? te_max : d + dl; acc--;
      end else if (ph == 0 && rem > acc + 1 && d > te_min) begin
        d = (d - dl < te_min) ? te_min : d - dl;
        if (acc < (64'd1 << ACC_W) - 1) acc++;
        if (d == te_min) ph = 1;
      end else if (ph == 0) begin
        ph = 1;
      end
    end
  endfunction

  // Expected outputs, advanced once per clock.
  bit   mb = 0, e_busy = 0, e_done = 0, e_step = 0, e_dir = 0;
  int   e_num = 0, mc = 0, mT = 0;
  bit   sw[$];
  int   nw[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb = 0; e_busy = 0; e_done = 0; e_step = 0; e_dir = 0; e_num = 0;
    end else begin
      e_done = 0;
      if (mb) begin
        mc++;
        e_step = sw[mc];
        e_num  = nw[mc];
        if (mc == mT) begin mb = 0; e_busy = 0; e_done = 1; end
      end else begin
        e_step = 0;
        if (start) begin
          build(longint'(n_steps), longint'(t_max), longint'(t_min), longint'(delta), plan_stop);
          e_dir = dir_in; e_num = 0;
          if (bq.size() == 0) e_done = 1;
          else begin
            int s, k, cnt;
            mb = 1; mc = 0; e_busy = 1;
            mT = 0;
            foreach (bq[i]) mT += bq[i];
            sw.delete(); nw.delete();
            for (int c = 0; c <= mT; c++) begin sw.push_back(1'b0); nw.push_back(0); end
            s = 0;
            foreach (bq[i]) begin
              for (int j = 1; j <= bq[i] / 2; j++) sw[s + j] = 1'b1;
              s += bq[i];
            end
            k = 0; cnt = 0; s = bq[0];
            for (int c = 0; c <= mT; c++) begin
              while (k < bq.size() && s <= c) begin
                cnt++; k++;
                if (k < bq.size()) s += bq[k];
              end
              nw[c] = cnt;
            end
          end
        end
      end
    end
  end

  bit chk_en = 0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (chk_en) begin
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("step", 64'(step), 64'(e_step));
        chk("dir", 64'(dir), 64'(e_dir));
        chk("step_num", 64'(step_num), 64'(e_num));
      end
    end
  end

  task automatic pin(input string nm, input int ex[$]);
    chk({nm, "_len"}, 64'(bq.size()), 64'(ex.size()));
    foreach (ex[i]) if (i < bq.size()) chk(nm, 64'(bq[i]), 64'(ex[i]));
  endtask

  task automatic go_now(input int n, input int tmx, input int tmn, input int dl, input bit d);
    n_steps = n; t_max = tmx; t_min = tmn; delta = dl; dir_in = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic go(input int n, input int tmx, input int tmn, input int dl, input bit d);
    @(negedge clk);
    go_now(n, tmx, tmn, dl, d);
  endtask

  task automatic wait_done(input int lim);
    int i = 0;
    while (!e_done && i < lim) begin @(negedge clk); i++; end
    if (!e_done) begin n_cmp++; n_bad++; $display("FAIL wait_done: timeout after %0d cycles", lim); end
  endtask

  initial begin
    int ex[$];
    // Hand-computed period lists that pin the model.
    build(4, 10, 4, 3, 0);   ex = '{10, 7, 7, 10};                pin("per_n4", ex);
    build(8, 12, 4, 4, 0);   ex = '{12, 8, 4, 4, 4, 4, 8, 12};    pin("per_n8", ex);
    build(1, 6, 4, 1, 0);    ex = '{6};                           pin("per_n1", ex);
    build(0, 6, 4, 1, 0);    ex.delete();                         pin("per_n0", ex);
    build(3, 9, 3, 0, 0);    ex = '{9, 9, 9};                     pin("per_d0", ex);
    build(6, 10, 3, 4, 0);   ex = '{10, 6, 3, 3, 7, 10};          pin("per_nonmul", ex);
    build(3, 1, 0, 1, 0);    ex = '{2, 2, 2};                     pin("per_clamp2", ex);
    build(100, 12, 4, 4, 10);
    if (SOFT) begin
      chk("soft_len", 64'(bq.size()), 64'd12);
      chk("soft_p11", 64'(bq[10]), 64'd8);
      chk("soft_p12", 64'(bq[11]), 64'd12);
    end else begin
      chk("full_len", 64'(bq.size()), 64'd100);
      chk("full_last", 64'(bq[99]), 64'd12);
    end

    chk_en = 1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    go(4, 10, 4, 3, 1'b1);
    wait_done(200);
    @(negedge clk); #1;
    chk("n4_step_num", 64'(step_num), 64'd4);

    // Ignored mid-move start with toggled dir_in, then back-to-back on the done cycle.
    go(8, 12, 4, 4, 1'b0);
    repeat (20) @(negedge clk);
    n_steps = 3; dir_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk); dir_in = 1'b0;
    repeat (3) @(negedge clk); dir_in = 1'b1;
    wait_done(200);
    go_now(1, 6, 4, 1, 1'b0);
    wait_done(50);

    go(0, 6, 4, 1, 1'b1);
    @(negedge clk);
    go(3, 9, 3, 0, 1'b0);   wait_done(100);
    go(3, 1, 0, 1, 1'b1);   wait_done(100);
    go(6, 10, 3, 4, 1'b0);  wait_done(200);

    // Reset mid-move aborts, next move is normal.
    go(8, 12, 4, 4, 1'b1);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_step_num", 64'(step_num), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go(4, 10, 4, 3, 1'b0);
    wait_done(200);

    plan_stop = 10;
    go(100, 12, 4, 4, 1'b1);
    for (int i = 0; i < 500 && e_num != 9; i++) @(negedge clk);
    stop_req = 1'b1;
    wait_done(1000);
    @(negedge clk); #1;
    stop_req = 1'b0;
    chk("stop_step_num", 64'(step_num), SOFT ? 64'd12 : 64'd100);
    plan_stop = 0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
